// File: rtl/ad9866_gain_seq_if.sv
// rtl/ad9866_gain_seq_if.sv - gain write strobes, SPI handshake and status bundle for ad9866_gain_seq
interface ad9866_gain_seq_if;
  logic [5:0] rx_gain_in;
  logic       rx_gain_wr;
  logic [5:0] tx_gain_in;
  logic       tx_gain_wr;
  logic       sen_n;
  logic       ext_rx_rqst;
  logic [5:0] rx_gain;
  logic       ext_tx_rqst;
  logic [5:0] tx_gain;
  logic       init_done;
  logic       timeout_err;

  // host register path plus SPI engine side
  modport master (
    output rx_gain_in, rx_gain_wr, tx_gain_in, tx_gain_wr, sen_n,
    input  ext_rx_rqst, rx_gain, ext_tx_rqst, tx_gain, init_done, timeout_err
  );

  // gain sequencer side
  modport slave (
    input  rx_gain_in, rx_gain_wr, tx_gain_in, tx_gain_wr, sen_n,
    output ext_rx_rqst, rx_gain, ext_tx_rqst, tx_gain, init_done, timeout_err
  );
endinterface

// File: rtl/ad9866_gain_seq.sv
// rtl/ad9866_gain_seq.sv - sequences RX/TX gain writes into the AD9866 SPI engine after its init
module ad9866_gain_seq #(
  parameter int INIT_WRITES = 11,
  parameter int TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  ad9866_gain_seq_if.slave   bus
);

  localparam int ICW = (INIT_WRITES > 1) ? $clog2(INIT_WRITES + 1) : 1;

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    RQST_RX,
    DONE_RX,
    RQST_TX,
    DONE_TX
  } state_t;

  state_t         state;
  logic [ICW-1:0] init_cnt;
  logic [7:0]     tmo_cnt;
  logic           sen_q;
  logic           sen_fall;
  logic [5:0]     rx_shadow;
  logic [5:0]     tx_shadow;
  logic           rx_pending;
  logic           tx_pending;
  logic           last_tx;
  logic           go_rx;
  logic           go_tx;
  logic           ext_rx_rqst_q;
  logic           ext_tx_rqst_q;
  logic [5:0]     rx_gain_q;
  logic [5:0]     tx_gain_q;
  logic           init_done_q;
  logic           timeout_err_q;

  assign sen_fall = sen_q & ~bus.sen_n;

  // pick the channel to launch from IDLE; alternate when both are waiting
  always_comb begin
    go_rx = 1'b0;
    go_tx = 1'b0;
    if (state == IDLE) begin
      if (rx_pending && tx_pending) begin
        if (last_tx) go_rx = 1'b1;
        else         go_tx = 1'b1;
      end else if (rx_pending) begin
        go_rx = 1'b1;
      end else if (tx_pending) begin
        go_tx = 1'b1;
      end
    end
  end

  // chip-select history, shadow registers and pending flags; a new strobe beats a launch-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sen_q      <= 1'b1;
      rx_shadow  <= '0;
      tx_shadow  <= '0;
      rx_pending <= 1'b0;
      tx_pending <= 1'b0;
    end else begin
      sen_q <= bus.sen_n;
      if (bus.rx_gain_wr) begin
        rx_shadow  <= bus.rx_gain_in;
        rx_pending <= 1'b1;
      end else if (go_rx) begin
        rx_pending <= 1'b0;
      end
      if (bus.tx_gain_wr) begin
        tx_shadow  <= bus.tx_gain_in;
        tx_pending <= 1'b1;
      end else if (go_tx) begin
        tx_pending <= 1'b0;
      end
    end
  end

  // request sequencer: wait out the init frames, then one request/frame handshake at a time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= WAIT_INIT;
      init_cnt      <= '0;
      tmo_cnt       <= '0;
      last_tx       <= 1'b1;
      ext_rx_rqst_q <= 1'b0;
      ext_tx_rqst_q <= 1'b0;
      rx_gain_q     <= '0;
      tx_gain_q     <= '0;
      init_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state)
        WAIT_INIT: begin
          if (sen_fall) begin
            if (init_cnt == ICW'(INIT_WRITES - 1)) begin
              state       <= IDLE;
              init_done_q <= 1'b1;
            end else begin
              init_cnt <= init_cnt + 1'b1;
            end
          end
        end
        IDLE: begin
          if (go_rx) begin
            state         <= RQST_RX;
            rx_gain_q     <= rx_shadow;
            ext_rx_rqst_q <= 1'b1;
            tmo_cnt       <= '0;
            last_tx       <= 1'b0;
          end else if (go_tx) begin
            state         <= RQST_TX;
            tx_gain_q     <= tx_shadow;
            ext_tx_rqst_q <= 1'b1;
            tmo_cnt       <= '0;
            last_tx       <= 1'b1;
          end
        end
        RQST_RX: begin
          if (!bus.sen_n) begin
            state         <= DONE_RX;
            ext_rx_rqst_q <= 1'b0;
          end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
            state         <= IDLE;
            ext_rx_rqst_q <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE_RX: begin
          if (bus.sen_n) state <= IDLE;
        end
        RQST_TX: begin
          if (!bus.sen_n) begin
            state         <= DONE_TX;
            ext_tx_rqst_q <= 1'b0;
          end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
            state         <= IDLE;
            ext_tx_rqst_q <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE_TX: begin
          if (bus.sen_n) state <= IDLE;
        end
        default: state <= WAIT_INIT;
      endcase
    end
  end

  assign bus.ext_rx_rqst = ext_rx_rqst_q;
  assign bus.ext_tx_rqst = ext_tx_rqst_q;
  assign bus.rx_gain     = rx_gain_q;
  assign bus.tx_gain     = tx_gain_q;
  assign bus.init_done   = init_done_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ad9866_gain_seq.sv
// tb/tb_ad9866_gain_seq.sv - scoreboard bench for ad9866_gain_seq
module tb_ad9866_gain_seq;

  typedef struct packed {
    logic       tx;
    logic [5:0] gain;
  } exp_t;

  logic clk;
  logic reset_n;
  ad9866_gain_seq_if bus ();

  ad9866_gain_seq #(.INIT_WRITES(11), .TIMEOUT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         rqst_count = 0;
  exp_t       sb_q[$];
  logic       last_tx = 1'b0;
  logic [5:0] last_gain = '0;
  logic       prx = 1'b0;
  logic       ptx = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic tx, input logic [5:0] g);
    exp_t e;
    e.tx   = tx;
    e.gain = g;
    sb_q.push_back(e);
  endtask

  task automatic note_rise(input logic tx, input logic [5:0] g);
    exp_t e;
    rqst_count++;
    last_tx   = tx;
    last_gain = g;
    if (sb_q.size() == 0) begin
      check("unexpected_rqst", 32'(tx), 32'(!tx));
    end else begin
      e = sb_q.pop_front();
      check("rqst_chan", 32'(tx), 32'(e.tx));
      check("rqst_gain", 32'(g), 32'(e.gain));
    end
  endtask

  // request monitor: pops the scoreboard on every rising request, flags overlaps
  initial begin
    forever begin
      @(negedge clk);
      if (bus.ext_rx_rqst && bus.ext_tx_rqst) check("rqst_overlap", 32'(bus.ext_tx_rqst), 32'(!bus.ext_rx_rqst));
      if (bus.ext_rx_rqst && !prx) note_rise(1'b0, bus.rx_gain);
      if (bus.ext_tx_rqst && !ptx) note_rise(1'b1, bus.tx_gain);
      prx = bus.ext_rx_rqst;
      ptx = bus.ext_tx_rqst;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic init_frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.sen_n = 1'b0;
      repeat (32) @(negedge clk);
      bus.sen_n = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic strobe_rx(input logic [5:0] v);
    @(negedge clk);
    bus.rx_gain_in = v;
    bus.rx_gain_wr = 1'b1;
    @(negedge clk);
    bus.rx_gain_wr = 1'b0;
  endtask

  task automatic strobe_tx(input logic [5:0] v);
    @(negedge clk);
    bus.tx_gain_in = v;
    bus.tx_gain_wr = 1'b1;
    @(negedge clk);
    bus.tx_gain_wr = 1'b0;
  endtask

  task automatic strobe_both(input logic [5:0] rv, input logic [5:0] tv);
    @(negedge clk);
    bus.rx_gain_in = rv;
    bus.tx_gain_in = tv;
    bus.rx_gain_wr = 1'b1;
    bus.tx_gain_wr = 1'b1;
    @(negedge clk);
    bus.rx_gain_wr = 1'b0;
    bus.tx_gain_wr = 1'b0;
  endtask

  task automatic wait_rqst(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ext_rx_rqst || bus.ext_tx_rqst) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic serve();
    bit got;
    wait_rqst(got);
    check("rqst_wait", 32'(got), 32'd1);
    if (got) begin
      bus.sen_n = 1'b0;
      @(negedge clk);
      check("rqst_drop", 32'({bus.ext_rx_rqst, bus.ext_tx_rqst}), 32'd0);
      repeat (30) @(negedge clk);
      check("gain_hold", 32'(last_tx ? bus.tx_gain : bus.rx_gain), 32'(last_gain));
      bus.sen_n = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int  c0;
    int  hi;
    bit  got;
    reset_n        = 1'b0;
    bus.sen_n      = 1'b1;
    bus.rx_gain_in = '0;
    bus.rx_gain_wr = 1'b0;
    bus.tx_gain_in = '0;
    bus.tx_gain_wr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({bus.ext_rx_rqst, bus.rx_gain, bus.ext_tx_rqst, bus.tx_gain,
                             bus.init_done, bus.timeout_err}), 32'd0);
    reset_n = 1'b1;

    // power-up init, then a single RX write
    init_frames(10);
    check("init_done_early", 32'(bus.init_done), 32'd0);
    init_frames(1);
    check("init_done", 32'(bus.init_done), 32'd1);
    push_exp(1'b0, 6'h2A);
    strobe_rx(6'h2A);
    @(negedge clk);
    check("rx_rqst_latency", 32'(bus.ext_rx_rqst), 32'd1);
    serve();

    // write queued during init
    do_reset();
    init_frames(3);
    c0 = rqst_count;
    push_exp(1'b0, 6'h05);
    strobe_rx(6'h05);
    init_frames(7);
    check("no_rqst_in_init", 32'(rqst_count), 32'(c0));
    init_frames(1);
    repeat (5) @(negedge clk);
    check("one_rqst_after_init", 32'(rqst_count), 32'(c0 + 1));

    // TX served last, so both-pending goes RX first, twice in a row
    push_exp(1'b1, 6'h3F);
    strobe_tx(6'h3F);
    serve();
    push_exp(1'b0, 6'h10);
    push_exp(1'b1, 6'h20);
    strobe_both(6'h10, 6'h20);
    serve();
    serve();
    push_exp(1'b0, 6'h21);
    push_exp(1'b1, 6'h22);
    strobe_both(6'h21, 6'h22);
    serve();
    serve();

    // coalescing: 11 launches, 12 is overwritten by 13
    push_exp(1'b0, 6'h11);
    strobe_rx(6'h11);
    strobe_rx(6'h12);
    push_exp(1'b0, 6'h13);
    strobe_rx(6'h13);
    serve();
    serve();

    // TX request never answered
    check("timeout_err_clear", 32'(bus.timeout_err), 32'd0);
    push_exp(1'b1, 6'h07);
    strobe_tx(6'h07);
    wait_rqst(got);
    check("tx_rqst_seen", 32'(got), 32'd1);
    hi = got ? 1 : 0;
    for (int i = 0; i < 20 && got; i++) begin
      @(negedge clk);
      if (bus.ext_tx_rqst) hi++;
      else break;
    end
    check("tx_timeout_len", 32'(hi), 32'd8);
    check("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    repeat (5) @(negedge clk);
    push_exp(1'b0, 6'h09);
    strobe_rx(6'h09);
    serve();
    check("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);

    // reset while RX request is up, with a TX write still pending
    push_exp(1'b0, 6'h15);
    strobe_rx(6'h15);
    wait_rqst(got);
    check("rx_rqst_before_reset", 32'(bus.ext_rx_rqst), 32'd1);
    strobe_tx(6'h2B);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_async", 32'({bus.ext_rx_rqst, bus.rx_gain, bus.ext_tx_rqst, bus.tx_gain,
                              bus.init_done, bus.timeout_err}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    c0 = rqst_count;
    init_frames(10);
    check("reinit_done_early", 32'(bus.init_done), 32'd0);
    init_frames(1);
    repeat (10) @(negedge clk);
    check("reinit_done", 32'(bus.init_done), 32'd1);
    check("pending_lost", 32'(rqst_count), 32'(c0));

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
